fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter SIZE, default 32, instruction and address width.
REQ-002 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-004 SHALL have port RST  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port StallF  input  1  decode cannot accept the presented instruction this cycle.
REQ-006 SHALL have port RedirectE  input  1  taken branch or jump; discard all fetched work.
REQ-007 SHALL have port TargetE  input  SIZE  new fetch address, valid when RedirectE=1.
REQ-008 SHALL have port ImemReq  output  1  instruction memory request.
REQ-009 SHALL have port ImemAddr  output  SIZE  request address.
REQ-010 SHALL have port ImemReady  input  1  memory accepts the request this cycle.
REQ-011 SHALL have port ImemValid  input  1  response data valid this cycle.
REQ-012 SHALL have port ImemData  input  SIZE  response instruction.
REQ-013 SHALL have port InstrF  output  SIZE  instruction presented to the F/D pipeline register.
REQ-014 SHALL have port PCF  output  SIZE  address of InstrF.
REQ-015 SHALL have port ValidF  output  1  InstrF/PCF hold a real instruction.

Function
REQ-016 SHALL hold fetch address FPC, a 2-entry {pc,instr} FIFO with count 0..2, and a request FSM with states IDLE, WAIT, DROP.
REQ-017 SHALL allow at most one outstanding request; a request is outstanding from the accept cycle (ImemReq & ImemReady) until its ImemValid.
REQ-018 In IDLE, SHALL assert ImemReq with ImemAddr=FPC when count<2 and RedirectE=0.
REQ-019 SHALL keep ImemReq and ImemAddr stable until ImemReady, except on redirect.
REQ-020 On accept: FSM IDLE->WAIT; FPC <= FPC+4, modulo 2^SIZE (wrap, no flag).
REQ-021 In WAIT with ImemValid: push {request address, ImemData}; FSM->IDLE; the next request may issue the following cycle.
REQ-022 ImemValid in IDLE or DROP when no data is expected SHALL be ignored.
REQ-023 SHALL present the FIFO head combinationally: ValidF=(count!=0); InstrF/PCF = head entry, or 0 when empty (bubble).
REQ-024 SHALL pop the head when ValidF=1 and StallF=0; the same-cycle push and pop SHALL keep count unchanged and preserve order.
REQ-025 Push into a full FIFO SHALL NOT occur (guaranteed by REQ-018); with count=2 and StallF=1 no request issues.
REQ-026 RedirectE=1 SHALL take priority over pop, push and accept: FIFO cleared (count=0); FPC <= TargetE.
REQ-027 On redirect in WAIT without ImemValid: FSM->DROP; the next ImemValid is discarded and FSM->IDLE.
REQ-028 On redirect in WAIT with same-cycle ImemValid: data discarded; FSM->IDLE.
REQ-029 On redirect in IDLE with ImemReq high: no accept is recorded; the next cycle presents ImemAddr=TargetE.
REQ-030 On redirect in DROP: FSM stays in DROP; FPC <= TargetE.
REQ-031 A redirect SHALL produce ValidF=0 in the following cycle; the first target instruction appears no earlier than 3 cycles after the redirect with zero-wait memory.
REQ-032 Throughput with single-cycle memory: one instruction per 2 cycles sustained (request, response); no bubble is added beyond that.

Reset
REQ-033 RST=1 at posedge SHALL set FPC=RESET_PC, count=0, FSM=IDLE; ImemReq=0, ValidF=0, InstrF=0, PCF=0 in the cycle after.
REQ-034 Reset mid-WAIT or DROP SHALL abandon the outstanding request; the memory model is reset together with fetch_stage.
REQ-035 RST SHALL dominate RedirectE and StallF.

Verification
REQ-036 Reset then free-run, ready/valid 1-cycle, no stall -> ImemAddr 0,4,8,...; ValidF pulses with PCF 0,4,8 and InstrF = mem[PCF].
REQ-037 StallF=1 for 6 cycles -> count saturates at 2, ImemReq=0; after release, PCF order is unbroken and no instruction is lost or duplicated.
REQ-038 RedirectE with TargetE=0x100 while in WAIT -> late response discarded, ValidF=0 next cycle, next ImemAddr=0x100, next valid PCF=0x100.
REQ-039 RedirectE coincident with ImemValid and a pop -> FIFO empty, data dropped, FSM IDLE, ImemAddr=TargetE.
REQ-040 ImemReady held 0 for 4 cycles -> ImemReq=1, ImemAddr stable throughout; FPC wraps from 0xFFFFFFFC to 0 with SIZE=32.
REQ-041 RST asserted in WAIT -> all outputs per REQ-033; first post-reset ImemAddr=RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one-outstanding-request memory front end feeding a
// 2-entry {pc,instr} queue whose head is presented to the F/D register.
module fetch_stage #(
  parameter int unsigned     SIZE     = 32,
  parameter logic [SIZE-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            StallF,
  input  logic            RedirectE,
  input  logic [SIZE-1:0] TargetE,
  output logic            ImemReq,
  output logic [SIZE-1:0] ImemAddr,
  input  logic            ImemReady,
  input  logic            ImemValid,
  input  logic [SIZE-1:0] ImemData,
  output logic [SIZE-1:0] InstrF,
  output logic [SIZE-1:0] PCF,
  output logic            ValidF,
  output logic [1:0]      DbgState,
  output logic [1:0]      DbgCount
);

  // Memory handshake: a request transfers on a cycle with ImemReq & ImemReady;
  // ImemReq/ImemAddr hold until then (unless redirected). The response is the
  // single cycle with ImemValid while a request is outstanding (ST_WAIT).
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  localparam logic [SIZE-1:0] PC_STEP = SIZE'(4);

  state_e          state_q, state_d;
  logic [SIZE-1:0] fpc_q, fpc_d;
  logic [SIZE-1:0] req_pc_q, req_pc_d;
  logic [1:0]      count_q, count_d;
  logic [SIZE-1:0] pc_q [2];
  logic [SIZE-1:0] instr_q [2];
  logic [SIZE-1:0] pc_d [2];
  logic [SIZE-1:0] instr_d [2];
  logic            run_q;
  logic            accept;
  logic            push;
  logic            pop;
  logic            push_slot;

  // run_q keeps the request line quiet for the first cycle out of reset.
  assign ImemReq  = run_q && (state_q == ST_IDLE) && (count_q != 2'd2) && !RedirectE;
  assign ImemAddr = fpc_q;
  assign accept   = ImemReq && ImemReady;
  assign push     = (state_q == ST_WAIT) && ImemValid && !RedirectE;

  assign ValidF   = (count_q != 2'd0);
  assign pop      = ValidF && !StallF;
  assign InstrF   = ValidF ? instr_q[0] : '0;
  assign PCF      = ValidF ? pc_q[0]    : '0;

  assign DbgState = state_q;
  assign DbgCount = count_q;

  // Request FSM and fetch address; a redirect overrides any accept.
  always_comb begin
    state_d  = state_q;
    fpc_d    = fpc_q;
    req_pc_d = req_pc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_WAIT;
          fpc_d    = fpc_q + PC_STEP;
          req_pc_d = fpc_q;
        end
      end
      ST_WAIT: begin
        if (ImemValid)      state_d = ST_IDLE;
        else if (RedirectE) state_d = ST_DROP;
      end
      ST_DROP: begin
        if (ImemValid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (RedirectE) fpc_d = TargetE;
  end

  // Head lives in slot 0; a push lands behind whatever survives this cycle's pop.
  always_comb begin
    count_d   = count_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    push_slot = ((count_q == 2'd1) && !pop) || (count_q == 2'd2);
    if (RedirectE) begin
      count_d = '0;
    end else begin
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (pop) begin
        pc_d[0]    = pc_q[1];
        instr_d[0] = instr_q[1];
      end
      if (push) begin
        if (push_slot) begin
          pc_d[1]    = req_pc_q;
          instr_d[1] = ImemData;
        end else begin
          pc_d[0]    = req_pc_q;
          instr_d[0] = ImemData;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      fpc_q    <= RESET_PC;
      req_pc_q <= '0;
      count_q  <= '0;
      run_q    <= 1'b0;
      pc_q     <= '{default: '0};
      instr_q  <= '{default: '0};
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      req_pc_q <= req_pc_d;
      count_q  <= count_d;
      run_q    <= 1'b1;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a one-outstanding-request memory model.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        StallF;
  logic        RedirectE;
  logic [31:0] TargetE;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemReady;
  logic        ImemValid;
  logic [31:0] ImemData;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic        ValidF;
  logic [1:0]  DbgState;
  logic [1:0]  DbgCount;

  int checks = 0;
  int errors = 0;

  logic        pend;
  logic [31:0] pend_addr;
  logic        resp_en;

  fetch_stage #(.SIZE(32), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .RST(RST), .StallF(StallF), .RedirectE(RedirectE), .TargetE(TargetE),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemReady(ImemReady),
    .ImemValid(ImemValid), .ImemData(ImemData),
    .InstrF(InstrF), .PCF(PCF), .ValidF(ValidF),
    .DbgState(DbgState), .DbgCount(DbgCount)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'd7 + 32'h1234_5678;
  endfunction

  // Memory: responds the cycle after accept unless resp_en holds the response back.
  assign ImemValid = pend && resp_en;
  assign ImemData  = ImemValid ? mem_word(pend_addr) : 32'h0;

  always @(posedge CLK) begin
    if (RST) begin
      pend <= 1'b0;
    end else begin
      if (ImemValid) pend <= 1'b0;
      if (ImemReq && ImemReady) begin
        pend      <= 1'b1;
        pend_addr <= ImemAddr;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1; StallF = 1'b0; RedirectE = 1'b0; TargetE = '0;
    ImemReady = 1'b1; resp_en = 1'b1;
    tick(); tick();
    RST = 1'b0; #1;
    check("rst_req",   32'(ImemReq), 32'd0);
    check("rst_valid", 32'(ValidF),  32'd0);
    check("rst_instr", InstrF,       32'd0);
    check("rst_pc",    PCF,          32'd0);
    check("rst_state", 32'(DbgState), 32'd0);

    // free run, single-cycle memory
    tick();
    check("run_req0",  32'(ImemReq), 32'd1);
    check("run_addr0", ImemAddr,     32'd0);
    tick();
    check("run_wait_req",   32'(ImemReq),  32'd0);
    check("run_wait_valid", 32'(ValidF),   32'd0);
    check("run_wait_state", 32'(DbgState), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("run_valid", 32'(ValidF), 32'd1);
      check("run_pcf",   PCF,         32'(4 * k));
      check("run_instr", InstrF,      mem_word(32'(4 * k)));
      check("run_addr",  ImemAddr,    32'(4 * (k + 1)));
      check("run_req",   32'(ImemReq), 32'd1);
      if (k < 3) begin
        tick();
        check("run_bubble", 32'(ValidF), 32'd0);
      end
    end

    // stall for six cycles: queue fills to 2 and requests stop
    StallF = 1'b1; #1;
    tick();
    check("stall_cnt1",  32'(DbgCount), 32'd1);
    check("stall_wait",  32'(DbgState), 32'd1);
    tick();
    check("stall_cnt2",  32'(DbgCount), 32'd2);
    check("stall_noreq", 32'(ImemReq),  32'd0);
    repeat (4) tick();
    check("stall_hold_req", 32'(ImemReq),  32'd0);
    check("stall_hold_cnt", 32'(DbgCount), 32'd2);
    check("stall_hold_pc",  PCF,           32'd12);
    check("stall_hold_val", 32'(ValidF),   32'd1);
    StallF = 1'b0; #1;
    tick();
    check("rel_pc16",   PCF,           32'd16);
    check("rel_addr20", ImemAddr,      32'd20);
    check("rel_req",    32'(ImemReq),  32'd1);
    tick();
    check("rel_bubble", 32'(ValidF),   32'd0);
    tick();
    check("rel_pc20",    PCF,      32'd20);
    check("rel_instr20", InstrF,   mem_word(32'd20));
    check("rel_addr24",  ImemAddr, 32'd24);

    // redirect while waiting on a late response
    resp_en = 1'b0; #1;
    tick();
    check("late_wait",  32'(DbgState), 32'd1);
    check("late_empty", 32'(ValidF),   32'd0);
    RedirectE = 1'b1; TargetE = 32'h100; #1;
    check("late_redir_req", 32'(ImemReq), 32'd0);
    tick();
    RedirectE = 1'b0; #1;
    check("late_drop",  32'(DbgState), 32'd2);
    check("late_valid", 32'(ValidF),   32'd0);
    check("late_req",   32'(ImemReq),  32'd0);
    resp_en = 1'b1; #1;
    tick();
    check("late_idle",   32'(DbgState), 32'd0);
    check("late_req100", 32'(ImemReq),  32'd1);
    check("late_addr",   ImemAddr,      32'h100);
    check("late_nodata", 32'(ValidF),   32'd0);
    tick();
    check("late_nodata2", 32'(ValidF), 32'd0);
    tick();
    check("late_tgt_valid", 32'(ValidF), 32'd1);
    check("late_tgt_pc",    PCF,         32'h100);
    check("late_tgt_instr", InstrF,      mem_word(32'h100));

    // redirect coincident with response and pop
    StallF = 1'b1; #1;
    tick();
    check("coin_wait",  32'(DbgState), 32'd1);
    check("coin_head",  PCF,           32'h100);
    check("coin_cnt",   32'(DbgCount), 32'd1);
    check("coin_rsp",   32'(ImemValid), 32'd1);
    StallF = 1'b0; RedirectE = 1'b1; TargetE = 32'h200; #1;
    tick();
    RedirectE = 1'b0; #1;
    check("coin_valid", 32'(ValidF),   32'd0);
    check("coin_cnt0",  32'(DbgCount), 32'd0);
    check("coin_idle",  32'(DbgState), 32'd0);
    check("coin_req",   32'(ImemReq),  32'd1);
    check("coin_addr",  ImemAddr,      32'h200);
    check("coin_instr", InstrF,        32'd0);

    // backpressure at the top of the address space, then wrap
    ImemReady = 1'b0; RedirectE = 1'b1; TargetE = 32'hFFFF_FFFC; #1;
    tick();
    RedirectE = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      check("bp_req",  32'(ImemReq), 32'd1);
      check("bp_addr", ImemAddr,     32'hFFFF_FFFC);
      tick();
    end
    ImemReady = 1'b1; #1;
    check("bp_req_last",  32'(ImemReq), 32'd1);
    check("bp_addr_last", ImemAddr,     32'hFFFF_FFFC);
    tick();
    check("wrap_wait", 32'(DbgState), 32'd1);
    tick();
    check("wrap_pc",    PCF,           32'hFFFF_FFFC);
    check("wrap_instr", InstrF,        mem_word(32'hFFFF_FFFC));
    check("wrap_addr",  ImemAddr,      32'd0);
    check("wrap_req",   32'(ImemReq),  32'd1);

    // reset while waiting; reset dominates redirect and stall
    tick();
    check("rw_wait", 32'(DbgState), 32'd1);
    RST = 1'b1; RedirectE = 1'b1; TargetE = 32'h300; StallF = 1'b1; #1;
    tick();
    RST = 1'b0; RedirectE = 1'b0; StallF = 1'b0; #1;
    check("rw_req",   32'(ImemReq),  32'd0);
    check("rw_valid", 32'(ValidF),   32'd0);
    check("rw_instr", InstrF,        32'd0);
    check("rw_pc",    PCF,           32'd0);
    check("rw_state", 32'(DbgState), 32'd0);
    check("rw_cnt",   32'(DbgCount), 32'd0);
    tick();
    check("rw_first_req",  32'(ImemReq), 32'd1);
    check("rw_first_addr", ImemAddr,     32'd0);
    tick();
    check("rw_first_wait", 32'(DbgState), 32'd1);
    tick();
    check("rw_first_valid", 32'(ValidF), 32'd1);
    check("rw_first_pc",    PCF,         32'd0);
    check("rw_first_instr", InstrF,      mem_word(32'd0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
